// File: rtl/mvm_pkg.sv
// mvm_pkg: shared FSM state type, default geometry and accumulator width check for mvm_engine
package mvm_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DEF_ROWS       = 8;
    localparam int DEF_COLS       = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 24;

    function automatic bit acc_width_ok(int acc_w, int data_w);
        return acc_w >= 2 * data_w;
    endfunction

endpackage

// File: rtl/mvm_fifo.sv
// mvm_fifo: show-ahead FIFO, head always at slot 0, one per A row plus one for B
module mvm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_full;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && !r_full && !i_clr;
    assign w_pop_ok  = i_pop && (r_cnt != '0) && !w_push_ok;
    assign o_head    = r_mem[0];
    assign o_full    = r_full;

    // occupancy; clr flushes ahead of any push or pop
    always_comb begin
        w_cnt_nxt = i_clr ? '0 : w_push_ok ? r_cnt + CW'(1) : w_pop_ok ? r_cnt - CW'(1) : r_cnt;
    end

    // count and full flag, full visible the cycle after the filling push
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CW'(DEPTH));
        end
    end

    // storage: push lands at the tail slot, pop shifts everything toward the head
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push_ok && 32'(r_cnt) == i)
                r_mem[i] <= i_data;
            else if (w_pop_ok)
                r_mem[i] <= r_mem[(i + 1) % DEPTH];
        end
    end

endmodule

// File: rtl/mvm_mac.sv
// mvm_mac: one systolic MAC cell; accumulates a*b and forwards b/enable to the next row (MVM_SIGNED_EN selects signed operands)
module mvm_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b_in,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic [DATA_WIDTH-1:0] o_b_out,
    output logic                  o_en_out
);
    localparam int PW = 2 * DATA_WIDTH;

`ifdef MVM_SIGNED_EN
    logic signed [PW-1:0] w_prod;
    assign w_prod = PW'($signed(i_a)) * PW'($signed(i_b_in));
`else
    logic [PW-1:0] w_prod;
    assign w_prod = PW'(i_a) * PW'(i_b_in);
`endif

    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_b;
    logic                 r_en;

    assign w_ext    = ACC_WIDTH'(w_prod);
    assign o_acc    = r_acc;
    assign o_b_out  = r_b;
    assign o_en_out = r_en;

    // accumulate modulo 2^ACC_WIDTH and pass b/enable one row down, one cycle later
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
            r_en  <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_b   <= '0;
            r_en  <= 1'b0;
        end else begin
            r_acc <= i_en ? r_acc + w_ext : r_acc;
            r_b   <= i_b_in;
            r_en  <= i_en;
        end
    end

endmodule

// File: rtl/mvm_engine.sv
// mvm_engine: C[r] = sum_k A[r][k]*B[k] on a FIFO-fed systolic MAC column; define MVM_SIGNED_EN for two's-complement operands
module mvm_engine
    import mvm_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
)(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_a_wr_en,
    input  logic [RW-1:0]             i_a_wr_row,
    input  logic [DATA_WIDTH-1:0]     i_a_wr_data,
    input  logic                      i_b_wr_en,
    input  logic [DATA_WIDTH-1:0]     i_b_wr_data,
    input  logic                      i_start,
    input  logic                      i_clr,
    output logic                      o_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_c_valid,
    output logic [ROWS*ACC_WIDTH-1:0] o_c_out,
    output logic                      o_wr_err
);
    localparam int            KW     = $clog2(ROWS + COLS);
    localparam logic [KW-1:0] K_LAST = KW'(ROWS + COLS - 2);

    if (!acc_width_ok(ACC_WIDTH, DATA_WIDTH)) begin : g_acc_chk
        $error("mvm_engine: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic            r_busy;
    logic            r_done;
    logic            r_c_valid;
    logic            r_wr_err;

    logic                  w_en [ROWS+1];
    logic [DATA_WIDTH-1:0] w_b [ROWS+1];
    logic [DATA_WIDTH-1:0] w_a_head [ROWS];
    logic [ROWS-1:0]       w_a_push;
    logic [ROWS-1:0]       w_a_full;
    logic                  w_b_push;
    logic                  w_b_full;
    logic                  w_open;
    logic                  w_go;
    logic                  w_mac_clr;
    logic                  w_a_drop;
    logic                  w_b_drop;

    // writes only land outside CALC; clr in the same cycle wins and nothing is dropped
    assign w_open    = (r_state != CALC) && !i_clr;
    assign w_b_push  = w_open && i_b_wr_en && !w_b_full;
    assign w_a_drop  = i_a_wr_en && !i_clr && !(|w_a_push);
    assign w_b_drop  = i_b_wr_en && !i_clr && !w_b_push;
    assign o_ready   = (&w_a_full) && w_b_full;
    assign w_go      = (r_state != CALC) && i_start && o_ready && !i_clr;
    assign w_mac_clr = i_clr || w_go;
    assign w_en[0]   = (r_state == CALC) && (r_k < KW'(COLS));

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_c_valid = r_c_valid;
    assign o_wr_err  = r_wr_err;

    mvm_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(COLS)) u_b_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_push  (w_b_push),
        .i_pop   (w_en[0]),
        .i_data  (i_b_wr_data),
        .o_head  (w_b[0]),
        .o_full  (w_b_full)
    );

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign w_a_push[r] = w_open && i_a_wr_en && (i_a_wr_row == RW'(r)) && !w_a_full[r];

        mvm_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(COLS)) u_a_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (i_clr),
            .i_push  (w_a_push[r]),
            .i_pop   (w_en[r]),
            .i_data  (i_a_wr_data),
            .o_head  (w_a_head[r]),
            .o_full  (w_a_full[r])
        );

        mvm_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_en     (w_en[r]),
            .i_clr    (w_mac_clr),
            .i_a      (w_a_head[r]),
            .i_b_in   (w_b[r]),
            .o_acc    (o_c_out[r*ACC_WIDTH +: ACC_WIDTH]),
            .o_b_out  (w_b[r+1]),
            .o_en_out (w_en[r+1])
        );
    end

    // control FSM: IDLE/DONE load, CALC runs ROWS+COLS-1 cycles, done pulses on DONE entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_c_valid <= 1'b0;
            r_wr_err  <= 1'b0;
        end else if (i_clr) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_c_valid <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_a_drop || w_b_drop)
                r_wr_err <= 1'b1;
            if (w_go) begin
                r_state   <= CALC;
                r_k       <= '0;
                r_busy    <= 1'b1;
                r_c_valid <= 1'b0;
            end else if (r_state == CALC) begin
                if (r_k == K_LAST) begin
                    r_state   <= DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_c_valid <= 1'b1;
                end else begin
                    r_k <= r_k + KW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mvm_engine.sv
// tb_mvm_engine: directed checks of mvm_engine (8x8 default instance plus a 3x5 instance)
module tb_mvm_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_wr_en = 0, b_wr_en = 0, start = 0, clr = 0;
    logic [2:0]  a_wr_row = 0;
    logic [7:0]  a_wr_data = 0, b_wr_data = 0;
    logic        ready, busy, done, c_valid, wr_err;
    logic [191:0] c_out;

    logic        t3_a_wr_en = 0, t3_b_wr_en = 0, t3_start = 0, t3_clr = 0;
    logic [1:0]  t3_a_wr_row = 0;
    logic [7:0]  t3_a_wr_data = 0, t3_b_wr_data = 0;
    logic        t3_ready, t3_busy, t3_done, t3_c_valid, t3_wr_err;
    logic [71:0] t3_c_out;

    mvm_engine dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_wr_en(a_wr_en), .i_a_wr_row(a_wr_row), .i_a_wr_data(a_wr_data),
        .i_b_wr_en(b_wr_en), .i_b_wr_data(b_wr_data),
        .i_start(start), .i_clr(clr),
        .o_ready(ready), .o_busy(busy), .o_done(done), .o_c_valid(c_valid),
        .o_c_out(c_out), .o_wr_err(wr_err)
    );

    mvm_engine #(.ROWS(3), .COLS(5)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_wr_en(t3_a_wr_en), .i_a_wr_row(t3_a_wr_row), .i_a_wr_data(t3_a_wr_data),
        .i_b_wr_en(t3_b_wr_en), .i_b_wr_data(t3_b_wr_data),
        .i_start(t3_start), .i_clr(t3_clr),
        .o_ready(t3_ready), .o_busy(t3_busy), .o_done(t3_done), .o_c_valid(t3_c_valid),
        .o_c_out(t3_c_out), .o_wr_err(t3_wr_err)
    );

    int n_pass = 0;
    int n_chk  = 0;

    logic [7:0]  ma [64];
    logic [7:0]  mb [8];
    logic [23:0] ex [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1;
        tick();
        clr = 0;
    endtask

    // write the first na A elements row-major, then all of B
    task automatic load8(input int na);
        for (int i = 0; i < na; i++) begin
            a_wr_en = 1; a_wr_row = 3'(i / 8); a_wr_data = ma[i];
            tick();
        end
        a_wr_en = 0;
        for (int k = 0; k < 8; k++) begin
            b_wr_en = 1; b_wr_data = mb[k];
            tick();
        end
        b_wr_en = 0;
    endtask

    task automatic run8(input string tag);
        int lat;
        start = 1;
        tick();
        start = 0;
        check({tag, " busy@entry"}, 64'(busy), 1);
        check({tag, " c_valid@entry"}, 64'(c_valid), 0);
        lat = 1;
        while (!done && lat < 64) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 16);
        check({tag, " c_valid"}, 64'(c_valid), 1);
        check({tag, " busy@done"}, 64'(busy), 0);
        check({tag, " ready@done"}, 64'(ready), 0);
        for (int r = 0; r < 8; r++)
            check($sformatf("%s row%0d", tag, r), 64'(c_out[r*24 +: 24]), 64'(ex[r]));
        tick();
        check({tag, " done pulse"}, 64'(done), 0);
        check({tag, " c_valid held"}, 64'(c_valid), 1);
    endtask

    task automatic set_identity(input int boff);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) ma[r*8+k] = (r == k) ? 8'd1 : 8'd0;
            mb[r] = 8'(r + boff);
            ex[r] = 24'(r + boff);
        end
    endtask

    initial begin
        int seen;
        int lat;
        tick();
        tick();
        check("rst ready", 64'(ready), 0);
        check("rst busy", 64'(busy), 0);
        check("rst done", 64'(done), 0);
        check("rst c_valid", 64'(c_valid), 0);
        check("rst c_out", 64'(|c_out), 0);
        check("rst wr_err", 64'(wr_err), 0);
        rst_n = 1;
        tick();

        // identity times 1..8
        set_identity(1);
        load8(64);
        check("ident ready", 64'(ready), 1);
        run8("ident");
        check("ident wr_err", 64'(wr_err), 0);

        // back-to-back reload in DONE: A[r][k]=r+k+1, B[k]=k+1 -> 204+36r
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) ma[r*8+k] = 8'(r + k + 1);
            mb[r] = 8'(r + 1);
            ex[r] = 24'(204 + 36 * r);
        end
        load8(64);
        check("b2b c_valid held", 64'(c_valid), 1);
        check("b2b old row0", 64'(c_out[23:0]), 1);
        check("b2b ready", 64'(ready), 1);
        run8("b2b");

        // all 0xFF
        do_clr();
        check("clr c_valid", 64'(c_valid), 0);
        check("clr c_out", 64'(|c_out), 0);
        for (int i = 0; i < 64; i++) ma[i] = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            mb[k] = 8'hFF;
`ifdef MVM_SIGNED_EN
            ex[k] = 24'd8;
`else
            ex[k] = 24'h07F008;
`endif
        end
        load8(64);
        run8("ff");

        // partial load: start ignored until the last A element arrives
        do_clr();
        set_identity(10);
        load8(63);
        check("part ready", 64'(ready), 0);
        start = 1;
        tick();
        start = 0;
        check("part start ignored", 64'(busy), 0);
        a_wr_en = 1; a_wr_row = 3'd7; a_wr_data = 8'd1;
        tick();
        a_wr_en = 0;
        check("part ready after last", 64'(ready), 1);
        run8("part");

        // dropped writes: ninth write to row 3, result unaffected
        do_clr();
        set_identity(0);
        for (int k = 0; k < 8; k++) begin
            mb[k] = 8'(2 * k + 1);
            ex[k] = 24'(2 * k + 1);
        end
        load8(64);
        check("err pre", 64'(wr_err), 0);
        a_wr_en = 1; a_wr_row = 3'd3; a_wr_data = 8'h55;
        tick();
        a_wr_en = 0;
        check("err a full", 64'(wr_err), 1);
        run8("err");
        do_clr();
        check("err clr", 64'(wr_err), 0);
        for (int k = 0; k < 9; k++) begin
            b_wr_en = 1; b_wr_data = 8'h11;
            tick();
        end
        b_wr_en = 0;
        check("err b full", 64'(wr_err), 1);
        do_clr();

        // clr beats a write in the same cycle: reload fits exactly
        clr = 1; a_wr_en = 1; a_wr_row = 3'd0; a_wr_data = 8'h77;
        tick();
        clr = 0; a_wr_en = 0;
        check("clr prio wr_err", 64'(wr_err), 0);
        load8(64);
        check("clr prio reload err", 64'(wr_err), 0);
        check("clr prio ready", 64'(ready), 1);

        // write in CALC dropped, then clr at CALC cycle 5
        start = 1;
        tick();
        start = 0;
        b_wr_en = 1; b_wr_data = 8'h22;
        tick();
        b_wr_en = 0;
        check("calc write err", 64'(wr_err), 1);
        repeat (4) tick();
        check("abort busy before", 64'(busy), 1);
        do_clr();
        check("abort busy", 64'(busy), 0);
        check("abort c_valid", 64'(c_valid), 0);
        check("abort c_out", 64'(|c_out), 0);
        check("abort wr_err", 64'(wr_err), 0);
        check("abort ready", 64'(ready), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("abort no done", 64'(seen), 0);
        load8(64);
        check("abort fifos empty", 64'(wr_err), 0);
        check("abort reload ready", 64'(ready), 1);

        // async reset at CALC cycle 5
        start = 1;
        tick();
        start = 0;
        b_wr_en = 1; b_wr_data = 8'h22;
        tick();
        b_wr_en = 0;
        repeat (4) tick();
        rst_n = 0;
        #1;
        check("arst busy", 64'(busy), 0);
        check("arst done", 64'(done), 0);
        check("arst c_valid", 64'(c_valid), 0);
        check("arst c_out", 64'(|c_out), 0);
        check("arst wr_err", 64'(wr_err), 0);
        check("arst ready", 64'(ready), 0);
        tick();
        rst_n = 1;
        tick();

        // 3x5 instance: bad row index, then A[r][k]=5r+k+1, B[k]=k+1 -> 55,130,205
        t3_a_wr_en = 1; t3_a_wr_row = 2'd3; t3_a_wr_data = 8'h01;
        tick();
        t3_a_wr_en = 0;
        check("r3 bad row err", 64'(t3_wr_err), 1);
        t3_clr = 1;
        tick();
        t3_clr = 0;
        check("r3 clr err", 64'(t3_wr_err), 0);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 5; k++) begin
                t3_a_wr_en = 1; t3_a_wr_row = 2'(r); t3_a_wr_data = 8'(5 * r + k + 1);
                t3_b_wr_en = (r == 0); t3_b_wr_data = 8'(k + 1);
                tick();
            end
        t3_a_wr_en = 0; t3_b_wr_en = 0;
        check("r3 ready", 64'(t3_ready), 1);
        t3_start = 1;
        tick();
        t3_start = 0;
        lat = 1;
        while (!t3_done && lat < 64) begin
            tick();
            lat++;
        end
        check("r3 latency", 64'(lat), 8);
        check("r3 c_valid", 64'(t3_c_valid), 1);
        check("r3 row0", 64'(t3_c_out[23:0]), 55);
        check("r3 row1", 64'(t3_c_out[47:24]), 130);
        check("r3 row2", 64'(t3_c_out[71:48]), 205);
        check("r3 wr_err", 64'(t3_wr_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
